sv_bus_arbiter: RTL and testbench

Shares the Supervision system bus between the 65C02 CPU, the audio DMA fetch and the video DMA, one bus slot per CPU clock enable. It latches DMA requests, picks an owner per slot with fixed priority and a CPU anti-starvation limit, and stalls the CPU through `cpu_rdy`. It drives the DMA address and bank for the top-level bus mux, and returns fetched bytes to the requesting engine.

---
 rtl/sv_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_sv_bus_arbiter.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sv_bus_arbiter.sv
// rtl/sv_bus_arbiter.sv - per-slot bus arbiter for CPU, audio DMA and video DMA.
// Optional SV_ARB_PERF_EN adds saturating slot/stall performance counters.
module sv_bus_arbiter #(
   parameter int CPU_STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   input  logic        cpu_req,
   output logic        cpu_rdy,
   input  logic        adma_req,
   input  logic [15:0] adma_addr,
   input  logic [2:0]  adma_bank,
   input  logic        vdma_req,
   input  logic [15:0] vdma_addr,
   input  logic [2:0]  vdma_bank,
   input  logic [7:0]  dbus_in,
   output logic        dma_sel,
   output logic [15:0] dma_addr,
   output logic [2:0]  dma_bank,
   output logic [1:0]  bus_owner,
   output logic [7:0]  adma_data,
   output logic        adma_done,
   output logic [7:0]  vdma_data,
   output logic        vdma_ack,
   output logic        adma_overrun,
   input  logic        overrun_clr
`ifdef SV_ARB_PERF_EN
   ,
   output logic [15:0] perf_adma,
   output logic [15:0] perf_vdma,
   output logic [15:0] perf_stall
`endif
);

   typedef enum logic [1:0] {
      OWN_CPU  = 2'd0,
      OWN_ADMA = 2'd1,
      OWN_VDMA = 2'd2
   } owner_t;

   localparam logic [2:0] STARVE_MAX = 3'(CPU_STARVE_MAX);

   owner_t     owner;
   owner_t     winner;
   logic       adma_pend;
   logic [2:0] run_cnt;
   logic       grant_adma;

   // adma_pend is the registered flag, so a request on the ce clk itself waits a slot
   always_comb begin
      winner = OWN_CPU;
      if (cpu_req && (run_cnt == STARVE_MAX))
         winner = OWN_CPU;
      else if (adma_pend)
         winner = OWN_ADMA;
      else if (vdma_req)
         winner = OWN_VDMA;
   end

   assign grant_adma = ce && (winner == OWN_ADMA);
   assign bus_owner  = owner;

   always_ff @(posedge clk) begin
      if (reset) begin
         owner        <= OWN_CPU;
         cpu_rdy      <= 1'b1;
         dma_sel      <= 1'b0;
         dma_addr     <= 16'd0;
         dma_bank     <= 3'd0;
         adma_data    <= 8'd0;
         vdma_data    <= 8'd0;
         adma_done    <= 1'b0;
         vdma_ack     <= 1'b0;
         adma_overrun <= 1'b0;
         adma_pend    <= 1'b0;
         run_cnt      <= 3'd0;
      end else begin
         adma_done <= 1'b0;
         vdma_ack  <= 1'b0;

         // A request landing on its own grant clk re-arms the flag
         if (adma_req)
            adma_pend <= 1'b1;
         else if (grant_adma)
            adma_pend <= 1'b0;

         if (adma_req && adma_pend && !grant_adma)
            adma_overrun <= 1'b1;
         else if (overrun_clr)
            adma_overrun <= 1'b0;

         if (ce) begin
            case (owner)
               OWN_ADMA: begin
                  adma_data <= dbus_in;
                  adma_done <= 1'b1;
               end
               OWN_VDMA: begin
                  vdma_data <= dbus_in;
                  vdma_ack  <= 1'b1;
               end
               default: ;
            endcase

            owner   <= winner;
            dma_sel <= (winner != OWN_CPU);
            cpu_rdy <= (winner == OWN_CPU);

            case (winner)
               OWN_ADMA: begin
                  dma_addr <= adma_addr;
                  dma_bank <= adma_bank;
               end
               OWN_VDMA: begin
                  dma_addr <= vdma_addr;
                  dma_bank <= vdma_bank;
               end
               default: ;
            endcase

            if (winner == OWN_CPU)
               run_cnt <= 3'd0;
            else if (run_cnt != STARVE_MAX)
               run_cnt <= run_cnt + 3'd1;
         end
      end
   end

`ifdef SV_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_adma  <= 16'd0;
         perf_vdma  <= 16'd0;
         perf_stall <= 16'd0;
      end else if (ce) begin
         if ((winner == OWN_ADMA) && (perf_adma != 16'hFFFF))
            perf_adma <= perf_adma + 16'd1;
         if ((winner == OWN_VDMA) && (perf_vdma != 16'hFFFF))
            perf_vdma <= perf_vdma + 16'd1;
         if (cpu_req && (winner != OWN_CPU) && (perf_stall != 16'hFFFF))
            perf_stall <= perf_stall + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sv_bus_arbiter.sv
// tb/tb_sv_bus_arbiter.sv - scoreboard testbench for sv_bus_arbiter.
module tb_sv_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ce = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_rdy;
   logic        adma_req = 1'b0;
   logic [15:0] adma_addr = 16'd0;
   logic [2:0]  adma_bank = 3'd0;
   logic        vdma_req = 1'b0;
   logic [15:0] vdma_addr = 16'd0;
   logic [2:0]  vdma_bank = 3'd0;
   logic [7:0]  dbus_in = 8'd0;
   logic        dma_sel;
   logic [15:0] dma_addr;
   logic [2:0]  dma_bank;
   logic [1:0]  bus_owner;
   logic [7:0]  adma_data;
   logic        adma_done;
   logic [7:0]  vdma_data;
   logic        vdma_ack;
   logic        adma_overrun;
   logic        overrun_clr = 1'b0;
`ifdef SV_ARB_PERF_EN
   logic [15:0] perf_adma;
   logic [15:0] perf_vdma;
   logic [15:0] perf_stall;
`endif

   sv_bus_arbiter #(.CPU_STARVE_MAX(4)) dut (
      .clk(clk), .reset(reset), .ce(ce), .cpu_req(cpu_req), .cpu_rdy(cpu_rdy),
      .adma_req(adma_req), .adma_addr(adma_addr), .adma_bank(adma_bank),
      .vdma_req(vdma_req), .vdma_addr(vdma_addr), .vdma_bank(vdma_bank),
      .dbus_in(dbus_in), .dma_sel(dma_sel), .dma_addr(dma_addr), .dma_bank(dma_bank),
      .bus_owner(bus_owner), .adma_data(adma_data), .adma_done(adma_done),
      .vdma_data(vdma_data), .vdma_ack(vdma_ack), .adma_overrun(adma_overrun),
      .overrun_clr(overrun_clr)
`ifdef SV_ARB_PERF_EN
      , .perf_adma(perf_adma), .perf_vdma(perf_vdma), .perf_stall(perf_stall)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int n_adone = 0;
   int n_vack = 0;
   int ce_idx = 0;
   int last_adone_ce = 0;
   int last_vack_ce = 0;
   logic [7:0] adma_q[$];
   logic [7:0] vdma_q[$];
   logic [1:0] open_owner = 2'd0;

   // Scoreboard: every data-return pulse must match the byte queued when its slot closed
   always @(negedge clk) begin
      logic [7:0] exp_byte;
      if (adma_done === 1'b1) begin
         n_adone++;
         last_adone_ce = ce_idx;
         n_checks++;
         if (adma_q.size() == 0) begin
            n_fail++;
            $display("FAIL adma_done_unexpected: got pulse with data %h, expected no pulse", adma_data);
         end else begin
            exp_byte = adma_q.pop_front();
            if (adma_data !== exp_byte) begin
               n_fail++;
               $display("FAIL adma_data: got %h, expected %h", adma_data, exp_byte);
            end
         end
      end
      if (vdma_ack === 1'b1) begin
         n_vack++;
         last_vack_ce = ce_idx;
         n_checks++;
         if (vdma_q.size() == 0) begin
            n_fail++;
            $display("FAIL vdma_ack_unexpected: got pulse with data %h, expected no pulse", vdma_data);
         end else begin
            exp_byte = vdma_q.pop_front();
            if (vdma_data !== exp_byte) begin
               n_fail++;
               $display("FAIL vdma_data: got %h, expected %h", vdma_data, exp_byte);
            end
         end
      end
   end

   task automatic tick(input logic c);
      @(negedge clk);
      ce = c;
      @(posedge clk);
      #1;
      if (c) ce_idx++;
   endtask

   // One idle clk then a ce clk; queues the byte the closing slot should return
   task automatic slot(input logic [1:0] exp_owner, input logic [7:0] d);
      tick(1'b0);
      dbus_in = d;
      if (open_owner == 2'd1) adma_q.push_back(d);
      else if (open_owner == 2'd2) vdma_q.push_back(d);
      tick(1'b1);
      open_owner = exp_owner;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(1'b0);
      tick(1'b1);
      tick(1'b0);
      n_checks++;
      if (cpu_rdy !== 1'b1 || bus_owner !== 2'd0 || dma_sel !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got rdy=%b owner=%0d sel=%b, expected 1 0 0", cpu_rdy, bus_owner, dma_sel);
      end
      n_checks++;
      if (dma_addr !== 16'd0 || dma_bank !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_addr: got %h/%0d, expected 0000/0", dma_addr, dma_bank);
      end
      n_checks++;
      if ({adma_data, vdma_data, adma_done, vdma_ack, adma_overrun} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_data: got %h %h %b %b %b, expected all 0", adma_data, vdma_data, adma_done, vdma_ack, adma_overrun);
      end
      reset = 1'b0;
      open_owner = 2'd0;
   endtask

   task automatic test_idle();
      int pulses0;
      pulses0 = n_adone + n_vack;
      cpu_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         slot(2'd0, 8'($urandom));
         n_checks++;
         if (cpu_rdy !== 1'b1 || bus_owner !== 2'd0 || dma_sel !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_slot%0d: got rdy=%b owner=%0d sel=%b, expected 1 0 0", i, cpu_rdy, bus_owner, dma_sel);
         end
      end
      tick(1'b0);
      n_checks++;
      if (n_adone + n_vack !== pulses0) begin
         n_fail++;
         $display("FAIL idle_pulses: got %0d pulses, expected 0", n_adone + n_vack - pulses0);
      end
   endtask

   task automatic test_adma_fetch();
      cpu_req = 1'b1;
      adma_addr = 16'h1234;
      adma_bank = 3'd3;
      adma_req = 1'b1;
      tick(1'b0);
      adma_req = 1'b0;
      tick(1'b0);
      tick(1'b1);
      open_owner = 2'd1;
      n_checks++;
      if (dma_sel !== 1'b1 || dma_addr !== 16'h1234 || dma_bank !== 3'd3 || cpu_rdy !== 1'b0 || bus_owner !== 2'd1) begin
         n_fail++;
         $display("FAIL adma_grant: got sel=%b addr=%h bank=%0d rdy=%b owner=%0d, expected 1 1234 3 0 1", dma_sel, dma_addr, dma_bank, cpu_rdy, bus_owner);
      end
      // ce held low: the slot must freeze
      for (int i = 0; i < 6; i++) tick(1'b0);
      n_checks++;
      if (bus_owner !== 2'd1 || dma_sel !== 1'b1 || adma_done !== 1'b0) begin
         n_fail++;
         $display("FAIL adma_freeze: got owner=%0d sel=%b done=%b, expected 1 1 0", bus_owner, dma_sel, adma_done);
      end
      slot(2'd0, 8'hA5);
      n_checks++;
      if (adma_done !== 1'b1 || adma_data !== 8'hA5 || cpu_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL adma_return: got done=%b data=%h rdy=%b, expected 1 a5 1", adma_done, adma_data, cpu_rdy);
      end
      n_checks++;
      if (dma_addr !== 16'h1234 || dma_bank !== 3'd3) begin
         n_fail++;
         $display("FAIL cpu_hold_addr: got %h/%0d, expected 1234/3", dma_addr, dma_bank);
      end
      tick(1'b0);
      n_checks++;
      if (adma_done !== 1'b0) begin
         n_fail++;
         $display("FAIL adma_done_width: got %b, expected 0", adma_done);
      end
   endtask

   task automatic test_same_clk();
      cpu_req = 1'b0;
      adma_addr = 16'h0BEE;
      adma_bank = 3'd5;
      tick(1'b0);
      adma_req = 1'b1;
      tick(1'b1);
      adma_req = 1'b0;
      open_owner = 2'd0;
      n_checks++;
      if (bus_owner !== 2'd0) begin
         n_fail++;
         $display("FAIL same_clk_defer: got owner %0d, expected 0", bus_owner);
      end
      slot(2'd1, 8'h00);
      n_checks++;
      if (bus_owner !== 2'd1 || dma_addr !== 16'h0BEE || dma_bank !== 3'd5) begin
         n_fail++;
         $display("FAIL same_clk_grant: got owner=%0d addr=%h bank=%0d, expected 1 0bee 5", bus_owner, dma_addr, dma_bank);
      end
      slot(2'd0, 8'h3C);
   endtask

   task automatic test_starve();
      logic [1:0] exp_own [10] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
      int acks0;
      tick(1'b0);
      acks0 = n_vack;
      cpu_req = 1'b1;
      vdma_req = 1'b1;
      vdma_addr = 16'h8000;
      vdma_bank = 3'd2;
      for (int i = 0; i < 10; i++) begin
         slot(exp_own[i], 8'($urandom));
         n_checks++;
         if (bus_owner !== exp_own[i] || cpu_rdy !== (exp_own[i] == 2'd0)) begin
            n_fail++;
            $display("FAIL starve_slot%0d: got owner=%0d rdy=%b, expected owner %0d", i, bus_owner, cpu_rdy, exp_own[i]);
         end
         if (exp_own[i] == 2'd2) begin
            n_checks++;
            if (dma_addr !== 16'h8000 || dma_bank !== 3'd2) begin
               n_fail++;
               $display("FAIL starve_addr%0d: got %h/%0d, expected 8000/2", i, dma_addr, dma_bank);
            end
         end
      end
      vdma_req = 1'b0;
      slot(2'd0, 8'h00);
      tick(1'b0);
      n_checks++;
      if (n_vack - acks0 !== 8) begin
         n_fail++;
         $display("FAIL starve_acks: got %0d vdma_ack pulses, expected 8", n_vack - acks0);
      end
   endtask

   task automatic test_priority();
      cpu_req = 1'b0;
      adma_addr = 16'h2222;
      vdma_addr = 16'h3333;
      vdma_req = 1'b1;
      adma_req = 1'b1;
      tick(1'b0);
      adma_req = 1'b0;
      slot(2'd1, 8'h00);
      n_checks++;
      if (bus_owner !== 2'd1 || dma_addr !== 16'h2222) begin
         n_fail++;
         $display("FAIL prio_adma: got owner=%0d addr=%h, expected 1 2222", bus_owner, dma_addr);
      end
      slot(2'd2, 8'hA1);
      n_checks++;
      if (bus_owner !== 2'd2 || dma_addr !== 16'h3333 || adma_done !== 1'b1) begin
         n_fail++;
         $display("FAIL prio_vdma: got owner=%0d addr=%h done=%b, expected 2 3333 1", bus_owner, dma_addr, adma_done);
      end
      vdma_req = 1'b0;
      slot(2'd0, 8'hB2);
      n_checks++;
      if (bus_owner !== 2'd0 || vdma_ack !== 1'b1 || adma_done !== 1'b0) begin
         n_fail++;
         $display("FAIL prio_ack: got owner=%0d ack=%b done=%b, expected 0 1 0", bus_owner, vdma_ack, adma_done);
      end
      tick(1'b0);
      n_checks++;
      if (last_vack_ce - last_adone_ce !== 1) begin
         n_fail++;
         $display("FAIL prio_order: got ack-done distance %0d ce, expected 1", last_vack_ce - last_adone_ce);
      end
   endtask

   task automatic test_overrun();
      int slots_adma;
      cpu_req = 1'b1;
      adma_addr = 16'h5555;
      adma_req = 1'b1;
      tick(1'b0);
      tick(1'b0);
      adma_req = 1'b0;
      n_checks++;
      if (adma_overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_set: got %b, expected 1", adma_overrun);
      end
      slots_adma = 0;
      for (int i = 0; i < 4; i++) begin
         slot(i == 0 ? 2'd1 : 2'd0, 8'h5A + 8'(i));
         if (bus_owner == 2'd1) slots_adma++;
      end
      n_checks++;
      if (slots_adma !== 1 || adma_overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_sticky: got %0d adma slots, overrun=%b, expected 1 slot, 1", slots_adma, adma_overrun);
      end
      adma_req = 1'b1;
      tick(1'b0);
      overrun_clr = 1'b1;
      tick(1'b0);
      adma_req = 1'b0;
      n_checks++;
      if (adma_overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_set_wins: got %b, expected 1", adma_overrun);
      end
      tick(1'b0);
      overrun_clr = 1'b0;
      n_checks++;
      if (adma_overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_clr: got %b, expected 0", adma_overrun);
      end
      slot(2'd1, 8'h00);
      slot(2'd0, 8'h77);
   endtask

   task automatic test_back_to_back();
      cpu_req = 1'b0;
      adma_addr = 16'h4000;
      adma_bank = 3'd1;
      adma_req = 1'b1;
      tick(1'b0);
      adma_req = 1'b0;
      tick(1'b1);
      open_owner = 2'd1;
      adma_addr = 16'h4001;
      adma_req = 1'b1;
      tick(1'b0);
      // New request on the grant clk must survive as a third pending fetch
      dbus_in = 8'hC3;
      adma_q.push_back(8'hC3);
      tick(1'b1);
      adma_req = 1'b0;
      n_checks++;
      if (bus_owner !== 2'd1 || dma_addr !== 16'h4001 || adma_done !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_regrant: got owner=%0d addr=%h done=%b, expected 1 4001 1", bus_owner, dma_addr, adma_done);
      end
      adma_addr = 16'h4002;
      slot(2'd1, 8'hD4);
      n_checks++;
      if (bus_owner !== 2'd1 || dma_addr !== 16'h4002 || adma_overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_pend_kept: got owner=%0d addr=%h overrun=%b, expected 1 4002 0", bus_owner, dma_addr, adma_overrun);
      end
      slot(2'd0, 8'hE5);
   endtask

   task automatic test_reset_mid_slot();
      int done0;
      cpu_req = 1'b1;
      adma_req = 1'b1;
      tick(1'b0);
      adma_req = 1'b0;
      tick(1'b1);
      n_checks++;
      if (bus_owner !== 2'd1) begin
         n_fail++;
         $display("FAIL rst_mid_grant: got owner %0d, expected 1", bus_owner);
      end
      reset = 1'b1;
      tick(1'b0);
      reset = 1'b0;
      open_owner = 2'd0;
      n_checks++;
      if (dma_sel !== 1'b0 || cpu_rdy !== 1'b1 || bus_owner !== 2'd0) begin
         n_fail++;
         $display("FAIL rst_mid_state: got sel=%b rdy=%b owner=%0d, expected 0 1 0", dma_sel, cpu_rdy, bus_owner);
      end
`ifdef SV_ARB_PERF_EN
      n_checks++;
      if (perf_adma !== 16'd0 || perf_vdma !== 16'd0 || perf_stall !== 16'd0) begin
         n_fail++;
         $display("FAIL rst_mid_perf: got %0d %0d %0d, expected 0 0 0", perf_adma, perf_vdma, perf_stall);
      end
`endif
      done0 = n_adone;
      slot(2'd0, 8'h99);
      tick(1'b0);
      n_checks++;
      if (n_adone !== done0) begin
         n_fail++;
         $display("FAIL rst_mid_done: got %0d adma_done pulses, expected 0", n_adone - done0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_idle();
      test_adma_fetch();
      test_same_clk();
      test_starve();
      test_priority();
      test_overrun();
      test_back_to_back();
      test_reset_mid_slot();
      tick(1'b0);
      n_checks++;
      if (adma_q.size() != 0 || vdma_q.size() != 0) begin
         n_fail++;
         $display("FAIL queues_drained: got %0d/%0d outstanding, expected 0/0", adma_q.size(), vdma_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
